// File: rtl/keypad_scanner.sv
// keypad_scanner: drives a 4x4 active-low matrix keypad one row at a time,
// debounces both press and release, and emits exactly one single-cycle strobe
// with a 4-bit key code per accepted press.
// Ports:
//   clk      - system clock, all logic on the rising edge
//   reset    - synchronous, active-high reset
//   col_in   - keypad columns, active-low (0 = key in the driven row pressed)
//   row_out  - row drive, active-low one-hot
//   dout     - key code of the most recent accepted press
//   valid    - one-cycle strobe when dout is updated
//   key_held - high while the accepted key is still pressed
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] dout,
    output logic       valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // One extra state so the counter can hold DEBOUNCE_CNT itself.
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t           state,    state_d;
    logic [1:0]       row_idx,  row_idx_d;
    logic [DIV_W-1:0] div_cnt,  div_cnt_d;
    logic [DEB_W-1:0] deb_cnt,  deb_cnt_d;
    logic [3:0]       lat_cols, lat_cols_d;
    logic [1:0]       lat_col,  lat_col_d;
    logic [3:0]       row_out_d;
    logic [3:0]       dout_d;
    logic             valid_d;
    logic             key_held_d;
    logic [2:0]       sample;

    // {hit, index}: hit only when exactly one column is low; ghosting or
    // multiple keys in the driven row are treated as no key.
    function automatic logic [2:0] single_low(input logic [3:0] cols);
        logic [2:0] res;
        res = 3'b000;
        case (cols)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Keypad legend to code: digits are their value, A-D = 10-13, * = 14, # = 15.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'd0;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            4'hF: code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Next-state, counter and output logic.
    always_comb begin
        state_d    = state;
        row_idx_d  = row_idx;
        div_cnt_d  = div_cnt;
        deb_cnt_d  = deb_cnt;
        lat_cols_d = lat_cols;
        lat_col_d  = lat_col;
        dout_d     = dout;
        valid_d    = 1'b0;
        key_held_d = 1'b0;
        row_out_d  = row_out;
        sample     = single_low(col_in);

        case (state)
            ST_SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (sample[2]) begin
                        // Stay on this row; remember the exact column pattern.
                        lat_cols_d = col_in;
                        lat_col_d  = sample[1:0];
                        deb_cnt_d  = '0;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx + 2'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (col_in == lat_cols) begin
                    if (deb_cnt >= DEB_LAST) begin
                        deb_cnt_d = DEB_FULL;
                        state_d   = ST_EMIT;
                    end else begin
                        deb_cnt_d = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx + 2'd1;
                    div_cnt_d = '0;
                    deb_cnt_d = '0;
                end
            end

            ST_EMIT: begin
                deb_cnt_d = '0;
                state_d   = ST_HOLD;
            end

            ST_HOLD: begin
                // Only the latched column matters; a low sample restarts release.
                if (col_in[lat_col]) begin
                    if (deb_cnt >= DEB_LAST) begin
                        state_d   = ST_SCAN;
                        row_idx_d = row_idx + 2'd1;
                        div_cnt_d = '0;
                        deb_cnt_d = '0;
                    end else begin
                        deb_cnt_d = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase

        // Outputs are registered from the upcoming state.
        valid_d    = (state_d == ST_EMIT);
        key_held_d = (state_d == ST_HOLD);
        if (state_d == ST_EMIT) begin
            dout_d = key_code(row_idx, lat_col);
        end
        row_out_d = row_drive(row_idx_d);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_SCAN;
            row_idx  <= 2'd0;
            div_cnt  <= '0;
            deb_cnt  <= '0;
            lat_cols <= 4'hF;
            lat_col  <= 2'd0;
            row_out  <= 4'b1110;
            dout     <= 4'd0;
            valid    <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state    <= state_d;
            row_idx  <= row_idx_d;
            div_cnt  <= div_cnt_d;
            deb_cnt  <= deb_cnt_d;
            lat_cols <= lat_cols_d;
            lat_col  <= lat_col_d;
            row_out  <= row_out_d;
            dout     <= dout_d;
            valid    <= valid_d;
            key_held <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner. A keypad matrix
// model turns a per-cycle pressed-key mask into col_in; a timeline model
// predicts row drive, strobes, codes and hold from press/release times.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int MAXC     = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  dout;
    logic        valid;
    logic        key_held;
    logic [15:0] keys;

    int vectors     = 0;
    int miscompares = 0;

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .col_in  (col_in),
        .row_out (row_out),
        .dout    (dout),
        .valid   (valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its column low only while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row_out[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) col_in[c] = 1'b0;
    end

    // Key index = row*4 + col.
    int code_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    logic [3:0]  exp_row   [MAXC];
    logic        exp_valid [MAXC];
    logic [3:0]  exp_code  [MAXC];
    logic [3:0]  exp_dout  [MAXC];
    logic        exp_held  [MAXC];
    logic [15:0] exp_mask  [MAXC];
    logic [3:0]  obs_row   [MAXC];
    logic        obs_valid [MAXC];
    logic [3:0]  obs_dout  [MAXC];
    logic        obs_held  [MAXC];

    int m_len, m_o, m_r0, m_pulses, m_last_pulse, obs_pulses;

    function automatic logic [3:0] row_code(int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    function automatic void model_clear(int n);
        m_len = n; m_o = 0; m_r0 = 0; m_pulses = 0; m_last_pulse = -1;
        for (int i = 0; i < n; i++) begin
            exp_valid[i] = 1'b0; exp_held[i] = 1'b0; exp_mask[i] = 16'h0;
            exp_code[i] = 4'd0;  exp_row[i] = 4'hF;
        end
    endfunction

    // Free-running scan since the last time the scanner resumed at m_o on row m_r0.
    function automatic void fill_scan(int from, int to);
        for (int n = from; n < to && n < m_len; n++)
            exp_row[n] = row_code((m_r0 + (n - m_o) / SCAN_DIV) % 4);
    endfunction

    function automatic int next_sample(int r, int from);
        int t;
        t = m_o + SCAN_DIV - 1;
        while (t < from || ((m_r0 + (t - m_o) / SCAN_DIV) % 4) != r) t += SCAN_DIV;
        return t;
    endfunction

    // Key k low during cycles [s, e).
    function automatic void add_press(int k, int s, int e);
        int r, t, hs, h0;
        r = k / 4;
        for (int n = s; n < e && n < m_len; n++) exp_mask[n][k] = 1'b1;
        t = next_sample(r, (s > m_o) ? s : m_o);
        if (t >= e) return;
        fill_scan(m_o, t + 1);
        if (e <= t + DEB) begin
            // Released during debounce: rejected, scanning resumes on next row.
            for (int n = t + 1; n <= e && n < m_len; n++) exp_row[n] = row_code(r);
            m_o = e + 1;
        end else begin
            hs = t + DEB + 2;
            h0 = (e > hs) ? e : hs;
            for (int n = t + 1; n < h0 + DEB && n < m_len; n++) exp_row[n] = row_code(r);
            for (int n = hs; n < h0 + DEB && n < m_len; n++) exp_held[n] = 1'b1;
            if (t + DEB + 1 < m_len) begin
                exp_valid[t+DEB+1] = 1'b1;
                exp_code[t+DEB+1]  = 4'(code_tab[k]);
            end
            m_o = h0 + DEB;
            m_pulses++;
            m_last_pulse = t + DEB + 1;
        end
        m_r0 = (r + 1) % 4;
    endfunction

    function automatic void model_finalize();
        logic [3:0] d;
        d = 4'd0;
        fill_scan(m_o, m_len);
        for (int n = 0; n < m_len; n++) begin
            if (exp_valid[n]) d = exp_code[n];
            exp_dout[n] = d;
        end
    endfunction

    task automatic apply_reset(int n);
        reset = 1'b1;
        keys  = 16'h0;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    // Drive the modelled key mask for m_len cycles and record the outputs.
    task automatic run_window();
        obs_pulses = 0;
        for (int c = 0; c < m_len; c++) begin
            keys         = exp_mask[c];
            obs_row[c]   = row_out;
            obs_valid[c] = valid;
            obs_dout[c]  = dout;
            obs_held[c]  = key_held;
            if (valid === 1'b1) obs_pulses++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        apply_reset(3);
        vectors++; if (row_out !== 4'b1110) begin miscompares++; $display("FAIL reset row_out got=%b exp=1110", row_out); end
        vectors++; if (dout !== 4'd0) begin miscompares++; $display("FAIL reset dout got=%0d exp=0", dout); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset valid got=%b exp=0", valid); end
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset key_held got=%b exp=0", key_held); end
    endtask

    task automatic test_scan_rotation();
        apply_reset(3);
        model_clear(40);
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL rotation row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== 1'b0) begin miscompares++; $display("FAIL rotation valid cyc=%0d got=%b exp=0", c, obs_valid[c]); end
        end
    endtask

    task automatic test_single_hold();
        apply_reset(3);
        model_clear(90);
        add_press(5, 3, 43);
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL hold5 row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== exp_valid[c]) begin miscompares++; $display("FAIL hold5 valid cyc=%0d got=%b exp=%b", c, obs_valid[c], exp_valid[c]); end
            vectors++; if (obs_dout[c] !== exp_dout[c]) begin miscompares++; $display("FAIL hold5 dout cyc=%0d got=%0d exp=%0d", c, obs_dout[c], exp_dout[c]); end
            vectors++; if (obs_held[c] !== exp_held[c]) begin miscompares++; $display("FAIL hold5 key_held cyc=%0d got=%b exp=%b", c, obs_held[c], exp_held[c]); end
        end
        vectors++; if (obs_pulses !== 1) begin miscompares++; $display("FAIL hold5 pulse_count got=%0d exp=1", obs_pulses); end
        vectors++; if (obs_dout[m_len-1] !== 4'd5) begin miscompares++; $display("FAIL hold5 final_dout got=%0d exp=5", obs_dout[m_len-1]); end
    endtask

    task automatic test_sequence();
        int seq_k [8] = '{0, 2, 5, 13, 10, 0, 6, 13};
        int seq_v [8] = '{1, 3, 5, 0, 9, 1, 6, 0};
        int s, e, idx;
        apply_reset(3);
        model_clear(600);
        e = -28;
        for (int i = 0; i < 8; i++) begin
            s = e + 30;
            if (s < m_o) s = m_o;
            e = s + 30;
            add_press(seq_k[i], s, e);
        end
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL seq row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== exp_valid[c]) begin miscompares++; $display("FAIL seq valid cyc=%0d got=%b exp=%b", c, obs_valid[c], exp_valid[c]); end
            vectors++; if (obs_dout[c] !== exp_dout[c]) begin miscompares++; $display("FAIL seq dout cyc=%0d got=%0d exp=%0d", c, obs_dout[c], exp_dout[c]); end
            vectors++; if (obs_held[c] !== exp_held[c]) begin miscompares++; $display("FAIL seq key_held cyc=%0d got=%b exp=%b", c, obs_held[c], exp_held[c]); end
        end
        idx = 0;
        for (int c = 0; c < m_len; c++) begin
            if (obs_valid[c] === 1'b1 && idx < 8) begin
                vectors++; if (obs_dout[c] !== 4'(seq_v[idx])) begin miscompares++; $display("FAIL seq strobe%0d dout got=%0d exp=%0d", idx, obs_dout[c], seq_v[idx]); end
                idx++;
            end
        end
        vectors++; if (obs_pulses !== 8) begin miscompares++; $display("FAIL seq pulse_count got=%0d exp=8", obs_pulses); end
    endtask

    task automatic test_bounce();
        int s, p;
        apply_reset(3);
        model_clear(200);
        s = next_sample(2, 2);
        add_press(9, s, s + 5);
        add_press(9, s + 7, s + 10);
        p = next_sample(2, m_o + 20);
        add_press(9, p, p + 12);
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL bounce row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== exp_valid[c]) begin miscompares++; $display("FAIL bounce valid cyc=%0d got=%b exp=%b", c, obs_valid[c], exp_valid[c]); end
            vectors++; if (obs_dout[c] !== exp_dout[c]) begin miscompares++; $display("FAIL bounce dout cyc=%0d got=%0d exp=%0d", c, obs_dout[c], exp_dout[c]); end
            vectors++; if (obs_held[c] !== exp_held[c]) begin miscompares++; $display("FAIL bounce key_held cyc=%0d got=%b exp=%b", c, obs_held[c], exp_held[c]); end
        end
        vectors++; if (obs_pulses !== 1) begin miscompares++; $display("FAIL bounce pulse_count got=%0d exp=1", obs_pulses); end
        vectors++; if (obs_dout[m_len-1] !== 4'd8) begin miscompares++; $display("FAIL bounce final_dout got=%0d exp=8", obs_dout[m_len-1]); end
    endtask

    task automatic test_two_rows();
        apply_reset(3);
        model_clear(200);
        add_press(3, 1, 60);
        add_press(7, 1, 120);
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL tworow row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== exp_valid[c]) begin miscompares++; $display("FAIL tworow valid cyc=%0d got=%b exp=%b", c, obs_valid[c], exp_valid[c]); end
            vectors++; if (obs_dout[c] !== exp_dout[c]) begin miscompares++; $display("FAIL tworow dout cyc=%0d got=%0d exp=%0d", c, obs_dout[c], exp_dout[c]); end
            vectors++; if (obs_held[c] !== exp_held[c]) begin miscompares++; $display("FAIL tworow key_held cyc=%0d got=%b exp=%b", c, obs_held[c], exp_held[c]); end
        end
        vectors++; if (obs_pulses !== 2) begin miscompares++; $display("FAIL tworow pulse_count got=%0d exp=2", obs_pulses); end
    endtask

    task automatic test_same_row_ghost();
        apply_reset(3);
        model_clear(80);
        for (int n = 1; n < 60; n++) exp_mask[n] = 16'h0030;
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL ghost row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== 1'b0) begin miscompares++; $display("FAIL ghost valid cyc=%0d got=%b exp=0", c, obs_valid[c]); end
            vectors++; if (obs_held[c] !== 1'b0) begin miscompares++; $display("FAIL ghost key_held cyc=%0d got=%b exp=0", c, obs_held[c]); end
        end
    endtask

    task automatic test_reset_in_hold();
        apply_reset(3);
        model_clear(30);
        add_press(14, 0, 1000);
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL rsthold row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== exp_valid[c]) begin miscompares++; $display("FAIL rsthold valid cyc=%0d got=%b exp=%b", c, obs_valid[c], exp_valid[c]); end
            vectors++; if (obs_held[c] !== exp_held[c]) begin miscompares++; $display("FAIL rsthold key_held cyc=%0d got=%b exp=%b", c, obs_held[c], exp_held[c]); end
        end
        // '#' still pressed; one reset edge in the middle of HOLD.
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rsthold after_reset valid got=%b exp=0", valid); end
        vectors++; if (dout !== 4'd0) begin miscompares++; $display("FAIL rsthold after_reset dout got=%0d exp=0", dout); end
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL rsthold after_reset key_held got=%b exp=0", key_held); end
        vectors++; if (row_out !== 4'b1110) begin miscompares++; $display("FAIL rsthold after_reset row_out got=%b exp=1110", row_out); end
        reset = 1'b0;
        model_clear(60);
        add_press(14, 0, 40);
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL redetect row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== exp_valid[c]) begin miscompares++; $display("FAIL redetect valid cyc=%0d got=%b exp=%b", c, obs_valid[c], exp_valid[c]); end
            vectors++; if (obs_dout[c] !== exp_dout[c]) begin miscompares++; $display("FAIL redetect dout cyc=%0d got=%0d exp=%0d", c, obs_dout[c], exp_dout[c]); end
        end
        vectors++; if (obs_pulses !== 1) begin miscompares++; $display("FAIL redetect pulse_count got=%0d exp=1", obs_pulses); end
        vectors++; if (obs_dout[m_len-1] !== 4'd15) begin miscompares++; $display("FAIL redetect final_dout got=%0d exp=15", obs_dout[m_len-1]); end
    endtask

    task automatic test_random();
        int k, dur, gap, s, e, last_e;
        apply_reset(3);
        model_clear(3000);
        last_e = 0;
        forever begin
            k   = int'($urandom_range(0, 15));
            dur = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2, 12)) : int'($urandom_range(20, 60));
            gap = int'($urandom_range(1, 20));
            s   = last_e + gap;
            if (s < m_o) s = m_o;
            e   = s + dur;
            if (e + 40 > m_len) break;
            add_press(k, s, e);
            last_e = e;
        end
        model_finalize();
        run_window();
        for (int c = 0; c < m_len; c++) begin
            vectors++; if (obs_row[c] !== exp_row[c]) begin miscompares++; $display("FAIL random row_out cyc=%0d got=%b exp=%b", c, obs_row[c], exp_row[c]); end
            vectors++; if (obs_valid[c] !== exp_valid[c]) begin miscompares++; $display("FAIL random valid cyc=%0d got=%b exp=%b", c, obs_valid[c], exp_valid[c]); end
            vectors++; if (obs_dout[c] !== exp_dout[c]) begin miscompares++; $display("FAIL random dout cyc=%0d got=%0d exp=%0d", c, obs_dout[c], exp_dout[c]); end
            vectors++; if (obs_held[c] !== exp_held[c]) begin miscompares++; $display("FAIL random key_held cyc=%0d got=%b exp=%b", c, obs_held[c], exp_held[c]); end
        end
        vectors++; if (obs_pulses !== m_pulses) begin miscompares++; $display("FAIL random pulse_count got=%0d exp=%0d", obs_pulses, m_pulses); end
    endtask

    initial begin
        reset = 1'b1;
        keys  = 16'h0;
        test_reset();
        test_scan_rotation();
        test_single_hold();
        test_sequence();
        test_bounce();
        test_two_rows();
        test_same_row_ghost();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
